// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode constants, one-hot select type and shift-class predicate
package alu_pkg;
    localparam int PA_W = 15;
    typedef logic [PA_W-1:0] pa_sel_t;
    localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_ADC = 4'd2, OP_SUB = 4'd3,
                           OP_SBC = 4'd4, OP_NOT = 4'd5, OP_AND = 4'd6, OP_NLAND = 4'd7,
                           OP_RLC = 4'd8, OP_RL = 4'd9, OP_SLA = 4'd10, OP_RRC = 4'd11,
                           OP_RR = 4'd12, OP_SRA = 4'd13, OP_SRL = 4'd14, OP_ILLEGAL = 4'd15;
    function automatic logic is_shift(input logic [3:0] op);
        return op[3] && op != OP_ILLEGAL;
    endfunction
endpackage

// File: rtl/alu_op_onehot.sv
// alu_op_onehot: 4-to-15 one-hot opcode decoder; opcode 15 flags illegal and decodes as NOP
module alu_op_onehot
    import alu_pkg::*;
(
    input  logic [3:0] op,
    output pa_sel_t    sel,
    output logic       illegal
);
    assign illegal = op == OP_ILLEGAL;
    assign sel     = illegal ? pa_sel_t'(1) : pa_sel_t'(1) << op;
endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: valid/ready ALU opcode sequencer driving registered one-hot PA_* strobes
// ALU_ISSUE_ILLEGAL_TRAP_EN: trap opcode 15 into a sticky Illegal flag instead of issuing NOP
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int COUNT_W = 4
) (
    input  logic               CLK,
    input  logic               notRST,
    input  logic               OpValid,
    input  logic [3:0]         OpCode,
    input  logic [COUNT_W-1:0] OpCount,
    output logic               OpReady,
    input  logic               Stall,
    output logic               PA_NOP,
    output logic               PA_ADD,
    output logic               PA_ADC,
    output logic               PA_SUB,
    output logic               PA_SBC,
    output logic               PA_NOT,
    output logic               PA_AND,
    output logic               PA_NLAND,
    output logic               PA_RLC,
    output logic               PA_RL,
    output logic               PA_SLA,
    output logic               PA_RRC,
    output logic               PA_RR,
    output logic               PA_SRA,
    output logic               PA_SRL,
    output logic               Step,
    output logic               Done,
    output logic               Busy
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    ,
    output logic               Illegal
`endif
);
    localparam logic [0:0] IDLE = 1'b0, ISSUE = 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    logic [0:0]         state;
    logic [COUNT_W-1:0] cnt;
    pa_sel_t            pa, sel;
    logic               op_illegal, last, accept, trap;

    alu_op_onehot u_dec (.op(OpCode), .sel(sel), .illegal(op_illegal));

    assign Busy   = state == ISSUE;
    assign Step   = Busy && !Stall;
    assign last   = Step && cnt == '0;
    assign Done   = last;
    assign accept = OpValid && OpReady;
    assign trap   = accept && op_illegal && TRAP_EN;
    assign {PA_SRL, PA_SRA, PA_RR, PA_RRC, PA_SLA, PA_RL, PA_RLC, PA_NLAND,
            PA_AND, PA_NOT, PA_SBC, PA_SUB, PA_ADC, PA_ADD, PA_NOP} = pa;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign OpReady = !Illegal && (state == IDLE || last);
    always_ff @(posedge CLK or negedge notRST)
        if (!notRST)
            Illegal <= 1'b0;
        else if (trap)
            Illegal <= 1'b1;
`else
    assign OpReady = state == IDLE || last;
`endif

    // A trapped opcode is consumed but issues nothing, so it behaves like an end of operation.
    always_ff @(posedge CLK or negedge notRST)
        if (!notRST) begin
            state <= IDLE;
            cnt   <= '0;
            pa    <= '0;
        end else if (accept && !trap) begin
            state <= ISSUE;
            pa    <= sel;
            cnt   <= is_shift(OpCode) ? OpCount : '0;
        end else if (last || trap) begin
            state <= IDLE;
            pa    <= '0;
        end else if (Step) begin
            cnt   <= cnt - 1'b1;
        end
endmodule
